// File: rtl/ldmac_loader.sv
// ldmac_loader: buffers one full MAC job from the host stream, then seeds
// the LDMAC core and feeds key/message words on din as the core requests.
module ldmac_loader #(
  parameter int MSG_BLOCKS = 8,
  parameter int DW         = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          core_rst,
  output logic          load_s1,
  output logic          load_s2,
  output logic [DW-1:0] din,
  input  logic          load_k,
  input  logic          load_m,
  input  logic          done,
  output logic          busy,
  output logic          err
);

  localparam int NW  = 6 + MSG_BLOCKS;
  localparam int WW  = $clog2(NW);
  localparam int MW  = $clog2(MSG_BLOCKS + 1);
  localparam int MIW = (MSG_BLOCKS > 1) ? $clog2(MSG_BLOCKS) : 1;

  typedef enum logic [1:0] {
    COLLECT,
    SEED1,
    SEED2,
    RUN
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] sk  [6];
  logic [DW-1:0] msg [MSG_BLOCKS];

  logic [WW-1:0] wcnt;
  logic [WW-1:0] moff;
  logic [2:0]    kidx;
  logic [MW-1:0] midx;

  logic accept;
  logic last;
  logic k_ok;
  logic m_ok;

  assign accept = in_valid && (state == COLLECT);
  assign last   = (wcnt == WW'(NW - 1));
  assign moff   = wcnt - WW'(6);
  assign k_ok   = (kidx != 3'd4);
  assign m_ok   = (midx != MW'(MSG_BLOCKS));

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    core_rst = 1'b1;
    load_s1  = 1'b0;
    load_s2  = 1'b0;
    busy     = 1'b1;
    unique case (state)
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && last) state_nx = SEED1;
      end
      SEED1: begin
        load_s1  = 1'b1;
        state_nx = SEED2;
      end
      SEED2: begin
        load_s2  = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        core_rst = 1'b0;
        if (done) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // load_k is the core's same-cycle request, so it alone reaches din combinationally
  always_comb begin
    din = '0;
    unique case (state)
      SEED1: din = sk[0];
      SEED2: din = sk[1];
      RUN: begin
        if (load_k) begin
          if (k_ok) din = sk[3'd2 + kidx];
        end else if (m_ok) begin
          din = msg[midx[MIW-1:0]];
        end
      end
      default: din = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      wcnt  <= '0;
      kidx  <= '0;
      midx  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wcnt <= last ? '0 : wcnt + 1'b1;
        if (last) begin
          kidx <= '0;
          midx <= '0;
        end
      end
      if (state == RUN) begin
        if (load_k && k_ok) kidx <= kidx + 3'd1;
        if (load_m && m_ok) midx <= midx + 1'b1;
        if ((load_k && !k_ok) || (load_m && !m_ok) ||
            (done && (k_ok || m_ok)))
          err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (wcnt < WW'(6)) sk[wcnt[2:0]] <= in_data;
      else               msg[moff[MIW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_ldmac_loader.sv
// tb_ldmac_loader: streams jobs, models the core's strobes and
// scoreboards the expected din words against the loader.
module tb_ldmac_loader;

  localparam int MB = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          core_rst;
  logic          load_s1;
  logic          load_s2;
  logic [DW-1:0] din;
  logic          load_k = 1'b0;
  logic          load_m = 1'b0;
  logic          done = 1'b0;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  ldmac_loader #(.MSG_BLOCKS(MB), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_rst(core_rst), .load_s1(load_s1), .load_s2(load_s2),
    .din(din), .load_k(load_k), .load_m(load_m), .done(done),
    .busy(busy), .err(err)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] key_m [4];
  logic [DW-1:0] msg_m [MB];
  int kx;
  int mx;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    load_k = 1'b0;
    load_m = 1'b0;
    done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic send_job(input logic [DW-1:0] base, input bit gap);
    for (int i = 1; i <= 6 + MB; i++) begin
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      while (!in_ready && n < 50) begin
        cyc();
        n++;
      end
      if (!in_ready) check("ready_timeout", 0, 1);
      cyc();
      in_valid = 1'b0;
      if (gap && i == 3) cyc();
    end
    for (int j = 0; j < 4; j++) key_m[j] = base + DW'(3 + j);
    for (int j = 0; j < MB; j++) msg_m[j] = base + DW'(7 + j);
    kx = 0;
    mx = 0;
  endtask

  task automatic launch(input logic [DW-1:0] base);
    @(negedge clk);
    check("s1_strobe", load_s1, 1);
    check("s1_din", din, base + 1);
    check("s1_busy", busy, 1);
    check("s1_ready", in_ready, 0);
    cyc();
    @(negedge clk);
    check("s2_strobe", load_s2, 1);
    check("s2_din", din, base + 2);
    check("s2_crst", core_rst, 1);
    cyc();
    @(negedge clk);
    check("run_crst", core_rst, 0);
    check("run_din_m0", din, base + 7);
  endtask

  task automatic strobe(input bit k, input bit m);
    cyc();
    load_k = k;
    load_m = m;
    done = 1'b0;
    if (k) begin
      if (kx < 4) sb.push_back(key_m[kx]);
    end else if (m && mx < MB) begin
      sb.push_back(msg_m[mx]);
    end
    if (k && kx < 4) kx++;
    if (m && mx < MB) mx++;
    @(negedge clk);
    if (sb.size() > 0) check("din", din, sb.pop_front());
  endtask

  task automatic idle();
    cyc();
    load_k = 1'b0;
    load_m = 1'b0;
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_job(input bit exp_err);
    cyc();
    load_k = 1'b0;
    load_m = 1'b0;
    done = 1'b1;
    @(negedge clk);
    check("done_busy", busy, 1);
    cyc();
    done = 1'b0;
    @(negedge clk);
    check("post_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_crst", core_rst, 1);
    check("post_err", err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] b;
    do_reset();
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_crst", core_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_din", din, 0);

    // job 1: gap after word 3, messages, then keys in two bursts
    b = 64'hA5A5_0000_0000_0000;
    cyc();
    send_job(b, 1'b1);
    launch(b);
    cyc();
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0000;
    @(negedge clk);
    check("busy_ready", in_ready, 0);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < MB; i++) strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    idle();
    check("gap_din", din, 0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    finish_job(1'b0);

    // job 2: extra load_m after the last block
    b = 64'h3C3C_1111_0000_0000;
    send_job(b, 1'b0);
    launch(b);
    for (int i = 0; i < MB; i++) strobe(1'b0, 1'b1);
    idle();
    check("m_err_pre", err, 0);
    strobe(1'b0, 1'b1);
    idle();
    check("m_err_set", err, 1);
    do_reset();
    @(negedge clk);
    check("m_err_clr", err, 0);

    // job 3: fifth load_k
    b = 64'h7E7E_2222_0000_0000;
    cyc();
    send_job(b, 1'b0);
    launch(b);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
    idle();
    check("k_err_pre", err, 0);
    strobe(1'b1, 1'b0);
    idle();
    check("k_err_set", err, 1);
    finish_job(1'b1);
    idle();
    idle();
    check("k_err_hold", err, 1);
    do_reset();
    @(negedge clk);
    check("k_err_clr", err, 0);

    // job 4: reset mid-run after three messages
    b = 64'h0F0F_3333_0000_0000;
    cyc();
    send_job(b, 1'b0);
    launch(b);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1);
    cyc();
    load_m = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_crst", core_rst, 1);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    sb.delete();

    // job 5: fresh job with simultaneous key/message strobes
    b = 64'hC3C3_4444_0000_0000;
    cyc();
    send_job(b, 1'b0);
    launch(b);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b1);
    for (int i = 0; i < MB - 4; i++) strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    finish_job(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
